// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- bundle of every signal between the two requesters,
// the arbiter and the shared single-port RAM.
//
// Parameters: BIT (data word width), SZB (address width, RAM depth 2**SZB).
//
// Signal groups:
//   requester side : req0/1, we0/1, addr0/1, d0/1 (requester -> arbiter)
//                    gnt0/1, q0/1, busy           (arbiter -> requester)
//   RAM side       : ram_we, ram_addr, ram_d      (arbiter -> RAM)
//                    ram_q                        (RAM -> arbiter, combinational)
//   lock0/1        : only present when RAM_ARB_LOCK_EN is defined.
//
// Modports:
//   slave  -- the arbiter itself
//   master -- the requesters (fetch / load-store)
//   memory -- the RAM instance
interface ram_arbiter_if #(
  parameter int BIT = 8,
  parameter int SZB = 4
);
  logic           req0;
  logic           req1;
  logic           we0;
  logic           we1;
  logic [SZB-1:0] addr0;
  logic [SZB-1:0] addr1;
  logic [BIT-1:0] d0;
  logic [BIT-1:0] d1;
`ifdef RAM_ARB_LOCK_EN
  logic           lock0;
  logic           lock1;
`endif
  logic           gnt0;
  logic           gnt1;
  logic [BIT-1:0] q0;
  logic [BIT-1:0] q1;
  logic           busy;

  logic           ram_we;
  logic [SZB-1:0] ram_addr;
  logic [BIT-1:0] ram_d;
  logic [BIT-1:0] ram_q;

  modport slave (
`ifdef RAM_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    input  req0, req1, we0, we1, addr0, addr1, d0, d1,
    output gnt0, gnt1, q0, q1, busy,
    output ram_we, ram_addr, ram_d,
    input  ram_q
  );

  modport master (
`ifdef RAM_ARB_LOCK_EN
    output lock0, lock1,
`endif
    output req0, req1, we0, we1, addr0, addr1, d0, d1,
    input  gnt0, gnt1, q0, q1, busy
  );

  modport memory (
    input  ram_we, ram_addr, ram_d,
    output ram_q
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter -- shares one single-port RAM (async read, sync write)
// between two requesters with round-robin arbitration.
//
// Each access takes two cycles: the IDLE->ACCESS edge latches the winner's
// command onto the RAM pins, the ACCESS->IDLE edge completes it, captures
// read data into the winner's q register and pulses its gnt for one cycle.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ram_arbiter_if.slave (requester handshake + RAM pins)
//
// Optional feature: define RAM_ARB_LOCK_EN to add lock0/lock1. A winner
// whose lock is high keeps the priority pointer, so it wins the next
// contended selection as well (atomic read-modify-write). Without the
// macro the pointer always moves to the loser.
module ram_arbiter #(
  parameter int BIT = 8,
  parameter int SZB = 4
) (
  input  logic         clock,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t         state,      state_next;
  logic           owner,      owner_next;   // port being served in ACCESS
  logic           ptr,        ptr_next;     // port preferred under contention
  logic           ram_we_r,   ram_we_next;
  logic [SZB-1:0] ram_addr_r, ram_addr_next;
  logic [BIT-1:0] ram_d_r,    ram_d_next;
  logic           gnt0_r,     gnt0_next;
  logic           gnt1_r,     gnt1_next;
  logic [BIT-1:0] q0_r,       q0_next;
  logic [BIT-1:0] q1_r,       q1_next;
  logic           winner;

  // A lone requester wins outright; ptr only breaks ties.
  always_comb begin
    if (bus.req0 && bus.req1) winner = ptr;
    else                      winner = bus.req1;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next    = state;
    owner_next    = owner;
    ptr_next      = ptr;
    ram_we_next   = ram_we_r;
    ram_addr_next = ram_addr_r;
    ram_d_next    = ram_d_r;
    gnt0_next     = 1'b0;
    gnt1_next     = 1'b0;
    q0_next       = q0_r;
    q1_next       = q1_r;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_next    = ACCESS;
          owner_next    = winner;
          ram_we_next   = winner ? bus.we1   : bus.we0;
          ram_addr_next = winner ? bus.addr1 : bus.addr0;
          ram_d_next    = winner ? bus.d1    : bus.d0;
`ifdef RAM_ARB_LOCK_EN
          if (winner ? bus.lock1 : bus.lock0) ptr_next = winner;
          else                                ptr_next = ~winner;
`else
          ptr_next      = ~winner;
`endif
        end
      end

      ACCESS: begin
        // The RAM commits the write on this same edge; only reads
        // update the owner's q register.
        state_next  = IDLE;
        ram_we_next = 1'b0;
        if (owner) begin
          gnt1_next = 1'b1;
          if (!ram_we_r) q1_next = bus.ram_q;
        end else begin
          gnt0_next = 1'b1;
          if (!ram_we_r) q0_next = bus.ram_q;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Asynchronous reset also drops ram_we immediately, so an ACCESS cut
  // short by reset never writes the RAM and never issues a gnt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      ptr        <= 1'b0;
      ram_we_r   <= 1'b0;
      ram_addr_r <= '0;
      ram_d_r    <= '0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      q0_r       <= '0;
      q1_r       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state      <= state_next;
      owner      <= owner_next;
      ptr        <= ptr_next;
      ram_we_r   <= ram_we_next;
      ram_addr_r <= ram_addr_next;
      ram_d_r    <= ram_d_next;
      gnt0_r     <= gnt0_next;
      gnt1_r     <= gnt1_next;
      q0_r       <= q0_next;
      q1_r       <= q1_next;
    end
  end

  assign bus.busy     = (state == ACCESS);
  assign bus.gnt0     = gnt0_r;
  assign bus.gnt1     = gnt1_r;
  assign bus.q0       = q0_r;
  assign bus.q1       = q1_r;
  assign bus.ram_we   = ram_we_r;
  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_d    = ram_d_r;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter sharing one single-port RAM (async read, sync write, BIT-wide words, 2**SZB entries) between two requesters, e.g. instruction fetch (port 0) and load/store (port 1). It accepts a request per port with a held-request/grant-pulse handshake and picks one winner by round-robin. It drives the RAM for exactly one access cycle and returns registered read data to the winner. It sits between the CPU fetch/memory stages and the RAM instance.

## Interface

- BIT, 8, data word width
- SZB, 4, address width; RAM depth 2**SZB

Ports. Reset is asynchronous, active-high, on `reset`; the clock is `clock`.

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  access request, held until matching gnt
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  SZB  word address
- d0 / d1  in  BIT  write data
- gnt0 / gnt1  out  1  one-cycle completion pulse
- q0 / q1  out  BIT  read data for that port, valid from gnt high until the port's next grant
- busy  out  1  high while in ACCESS
- ram_we  out  1  RAM write enable
- ram_addr  out  SZB  RAM address
- ram_d  out  BIT  RAM write data
- ram_q  in  BIT  RAM read data (combinational from ram_addr)

## Operation

- FSM with two states, IDLE and ACCESS. Reset state is IDLE.
- **IDLE, at a rising edge with any req high:**
  - Select the winner.
  - Latch the winner's we, addr and d into ram_we, ram_addr and ram_d.
  - Record the owner and go to ACCESS.
- **IDLE with no req:** stay in IDLE. ram_we stays 0 and ram_addr/ram_d hold their previous values.
- **ACCESS, at the next edge:**
  - The RAM performs the write if ram_we is set.
  - For a read, capture ram_q into q_owner. q of a write-granted port is unchanged.
  - Pulse gnt_owner high for the following cycle.
  - Clear ram_we and return to IDLE.
- **Winner selection:**
  - Only one req high: that port wins.
  - Both high: the port indicated by the priority pointer `ptr` wins (reset 0, meaning port 0).
  - After every grant, ptr = inverse of the winner.
- **Handshake:**
  - A requester keeps req, we, addr and d stable until it sees gnt.
  - A req still high at the edge that ends the gnt cycle is a new request.
  - Dropping req before grant is illegal; behaviour is undefined.
- **Reset values:** gnt0 = gnt1 = 0, q0 = q1 = 0, busy = 0, ram_we = 0, ram_addr = 0, ram_d = 0, ptr = 0, state IDLE.
- **Reset mid-ACCESS:**
  - ram_we drops immediately (asynchronous). No write occurs at the next edge.
  - No gnt is issued and the transaction is lost.
  - The requester must re-issue after reset.
- Read-after-write to the same address by the other port returns the new data, because accesses are serialised.

## Timing

- Latency: req sampled at edge E0, RAM access during cycle E0–E1, gnt high during E1–E2, q valid from E1.
- Throughput: at most one access per 2 cycles; there is no back-to-back ACCESS.
- busy = 1 exactly during E0–E1.
- Worst-case wait under contention is 2 accesses (4 cycles) before grant.
- gnt0 and gnt1 are never high together. gnt is never high while busy is high.

## Configuration

- **RAM_ARB_LOCK_EN defined:**
  - Adds inputs lock0 and lock1, sampled with req.
  - If the winner's lock is high at the IDLE selection edge, ptr is set to the winner instead of toggled. The locked port keeps priority under contention for its next access, e.g. for atomic read-modify-write.
  - A single-requester win still grants normally.
- **Undefined:** the lock ports are absent and ptr always toggles.

## Test plan

- **Port 0 write then read:** req0, we0 = 1, addr0 = 3, d0 = 8'hA5.
  - gnt0 2 cycles after the sampling edge, and RAM[3] = A5.
  - Then a read of addr0 = 3 gives q0 = A5 with gnt0.
- **Simultaneous requests after reset:** both reqs (ptr = 0).
  - Port 0 is granted first and port 1 follows 2 cycles later.
  - gnt pulses never overlap.
- **Sustained contention, 4 requests per port held continuously:**
  - Grants alternate 0, 1, 0, 1, 0, 1, 0, 1, one every 2 cycles.
  - busy duty is 50%.
- **Reset mid-ACCESS:** assert reset during ACCESS of a write of 8'h3C to addr 5.
  - ram_we is 0 immediately, RAM[5] is unchanged, no gnt, and all outputs are at reset values.
- **Cross-port read-after-write:** port 1 writes 8'h77 to addr 9 while port 0 reads addr 9, with port 1 winning.
  - q0 = 77.
- **RAM_ARB_LOCK_EN:** port 1 wins with lock1 = 1, then both request.
  - Port 1 wins again. With lock1 = 0 on that access, port 0 wins next.
